// File: rtl/wave_frame_buffer_pkg.sv
// Shared constants, render-pipe payload and curve-hit helper for the wave frame buffer.
package wave_frame_buffer_pkg;

  localparam int unsigned LOG_WIDTH = 10;
  localparam int unsigned WIDTH     = 1 << LOG_WIDTH;
  localparam int unsigned RESOL     = 10;
  localparam int unsigned SHIFT     = 1;
  localparam int unsigned Y_BASE    = 640;
  localparam int unsigned THICK     = 1;
  localparam int unsigned HC_W      = 11;
  localparam int unsigned VC_W      = 10;
  localparam int unsigned ROW_W     = 12;

  typedef struct packed {
    logic            rd_bank;
    logic            in_range;
    logic [VC_W-1:0] vcount;
  } rd_stage_t;

  // True when pixel row vcount lies within THICK rows of the curve row for value.
  function automatic logic curve_hit(input logic [RESOL-1:0] value,
                                     input logic [VC_W-1:0]  vcount);
    logic signed [ROW_W-1:0] row;
    logic signed [ROW_W-1:0] diff;
    logic        [ROW_W-1:0] mag;
    row  = $signed(ROW_W'(Y_BASE)) - $signed(ROW_W'(value >> SHIFT));
    diff = $signed(ROW_W'(vcount)) - row;
    mag  = diff[ROW_W-1] ? $unsigned(-diff) : $unsigned(diff);
    return mag <= ROW_W'(THICK);
  endfunction

endpackage

// File: rtl/wave_bank_ram.sv
// Simple dual-port sample bank: one synchronous write port, one synchronous read port.
module wave_bank_ram #(
  parameter int unsigned DEPTH_LOG = 10,
  parameter int unsigned DATA_W    = 10
) (
  input  logic                 clock,
  input  logic                 wr_en,
  input  logic [DEPTH_LOG-1:0] wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [DEPTH_LOG-1:0] rd_addr,
  output logic [DATA_W-1:0]    rd_data
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  always_comb begin
    rd_data_d = mem_q[rd_addr];
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/wave_frame_buffer.sv
// Ping-pong profile capture with frame-aligned swap and a 2-clock curve renderer.
// Optional PREV_OVERLAY_EN adds prev_pixel drawn from a third bank holding the previous profile.
module wave_frame_buffer
  import wave_frame_buffer_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sample_valid,
  input  logic [LOG_WIDTH-1:0] sample_index,
  input  logic [RESOL-1:0]     sample_value,
  input  logic                 wave_ready,
  output logic                 buf_busy,
  output logic                 overflow,
  output logic                 swapped,
  input  logic [HC_W-1:0]      hcount,
  input  logic [VC_W-1:0]      vcount,
  input  logic                 vsync,
  output logic                 wave_pixel
`ifdef PREV_OVERLAY_EN
  ,
  output logic                 prev_pixel
`endif
);

  logic vs_d, vs_q;
  logic wr_bank_d, wr_bank_q;
  logic pending_d, pending_q;
  logic have_frame_d, have_frame_q;
  logic overflow_d, overflow_q;
  logic swapped_d, swapped_q;
  logic wave_pixel_d, wave_pixel_q;
  rd_stage_t st1_d, st1_q;

  logic frame_start_c;
  logic do_swap_c;
  logic blocked_c;
  logic wr_en_c;
  logic [LOG_WIDTH-1:0] disp_addr_c;
  logic [LOG_WIDTH-1:0] bank0_rd_addr_c;
  logic [LOG_WIDTH-1:0] bank1_rd_addr_c;
  logic [RESOL-1:0]     bank0_rd_data;
  logic [RESOL-1:0]     bank1_rd_data;
  logic [RESOL-1:0]     disp_data_c;

`ifdef PREV_OVERLAY_EN
  logic                 copy_active_d, copy_active_q;
  logic [LOG_WIDTH-1:0] copy_idx_d, copy_idx_q;
  logic                 copy_wr_d, copy_wr_q;
  logic [LOG_WIDTH-1:0] copy_addr_d, copy_addr_q;
  logic                 copy_src_d, copy_src_q;
  logic [1:0]           swap_cnt_d, swap_cnt_q;
  logic                 prev_ok_d, prev_ok_q;
  logic                 prev_pixel_d, prev_pixel_q;
  logic [RESOL-1:0]     prev_rd_data;
  logic [RESOL-1:0]     prev_wr_data_c;
`endif

  // Capture gating, pending/swap control and sticky overflow.
  always_comb begin
    vs_d          = vsync;
    wr_bank_d     = wr_bank_q;
    pending_d     = pending_q;
    have_frame_d  = have_frame_q;
    overflow_d    = overflow_q;
    swapped_d     = 1'b0;
    frame_start_c = vsync & ~vs_q;
    do_swap_c     = frame_start_c & (pending_q | wave_ready);
`ifdef PREV_OVERLAY_EN
    blocked_c     = pending_q | copy_active_q;
`else
    blocked_c     = pending_q;
`endif
    wr_en_c       = sample_valid & ~blocked_c;
    if (sample_valid && blocked_c) begin
      overflow_d = 1'b1;
    end
    if (do_swap_c) begin
      wr_bank_d    = ~wr_bank_q;
      pending_d    = 1'b0;
      have_frame_d = 1'b1;
      swapped_d    = 1'b1;
    end else if (wave_ready) begin
      pending_d = 1'b1;
    end
  end

`ifdef PREV_OVERLAY_EN
  // After each swap, walk the retired display bank into the previous-profile bank.
  always_comb begin
    copy_active_d = copy_active_q;
    copy_idx_d    = copy_idx_q;
    copy_wr_d     = 1'b0;
    copy_addr_d   = copy_idx_q;
    copy_src_d    = wr_bank_q;
    swap_cnt_d    = swap_cnt_q;
    prev_ok_d     = prev_ok_q;
    if (do_swap_c) begin
      copy_active_d = 1'b1;
      copy_idx_d    = '0;
      if (swap_cnt_q != 2'd2) begin
        swap_cnt_d = swap_cnt_q + 2'd1;
      end
    end else if (copy_active_q) begin
      copy_wr_d  = 1'b1;
      copy_idx_d = copy_idx_q + LOG_WIDTH'(1);
      if (copy_idx_q == LOG_WIDTH'(WIDTH - 1)) begin
        copy_active_d = 1'b0;
      end
    end
    if (copy_wr_q && (copy_addr_q == LOG_WIDTH'(WIDTH - 1)) && (swap_cnt_q == 2'd2)) begin
      prev_ok_d = 1'b1;
    end
    prev_wr_data_c = copy_src_q ? bank1_rd_data : bank0_rd_data;
  end
`endif

  // Bank read addressing: display reads rd_bank, copy (if any) reads wr_bank.
  always_comb begin
    disp_addr_c     = hcount[LOG_WIDTH-1:0];
    bank0_rd_addr_c = disp_addr_c;
    bank1_rd_addr_c = disp_addr_c;
`ifdef PREV_OVERLAY_EN
    if (copy_active_q) begin
      if (wr_bank_q) begin
        bank1_rd_addr_c = copy_idx_q;
      end else begin
        bank0_rd_addr_c = copy_idx_q;
      end
    end
`endif
  end

  // Render pipe: stage 1 alongside RAM read, stage 2 row compare.
  always_comb begin
    st1_d.rd_bank  = ~wr_bank_q;
    st1_d.in_range = hcount < HC_W'(WIDTH);
    st1_d.vcount   = vcount;
    disp_data_c    = st1_q.rd_bank ? bank1_rd_data : bank0_rd_data;
    wave_pixel_d   = have_frame_q & st1_q.in_range & curve_hit(disp_data_c, st1_q.vcount);
`ifdef PREV_OVERLAY_EN
    prev_pixel_d   = prev_ok_q & st1_q.in_range & curve_hit(prev_rd_data, st1_q.vcount);
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vs_q         <= 1'b0;
      wr_bank_q    <= 1'b0;
      pending_q    <= 1'b0;
      have_frame_q <= 1'b0;
      overflow_q   <= 1'b0;
      swapped_q    <= 1'b0;
      wave_pixel_q <= 1'b0;
      st1_q        <= '0;
`ifdef PREV_OVERLAY_EN
      copy_active_q <= 1'b0;
      copy_idx_q    <= '0;
      copy_wr_q     <= 1'b0;
      copy_addr_q   <= '0;
      copy_src_q    <= 1'b0;
      swap_cnt_q    <= 2'd0;
      prev_ok_q     <= 1'b0;
      prev_pixel_q  <= 1'b0;
`endif
    end else begin
      vs_q         <= vs_d;
      wr_bank_q    <= wr_bank_d;
      pending_q    <= pending_d;
      have_frame_q <= have_frame_d;
      overflow_q   <= overflow_d;
      swapped_q    <= swapped_d;
      wave_pixel_q <= wave_pixel_d;
      st1_q        <= st1_d;
`ifdef PREV_OVERLAY_EN
      copy_active_q <= copy_active_d;
      copy_idx_q    <= copy_idx_d;
      copy_wr_q     <= copy_wr_d;
      copy_addr_q   <= copy_addr_d;
      copy_src_q    <= copy_src_d;
      swap_cnt_q    <= swap_cnt_d;
      prev_ok_q     <= prev_ok_d;
      prev_pixel_q  <= prev_pixel_d;
`endif
    end
  end

  wave_bank_ram #(.DEPTH_LOG(LOG_WIDTH), .DATA_W(RESOL)) u_bank0 (
    .clock   (clock),
    .wr_en   (wr_en_c & ~wr_bank_q),
    .wr_addr (sample_index),
    .wr_data (sample_value),
    .rd_addr (bank0_rd_addr_c),
    .rd_data (bank0_rd_data)
  );

  wave_bank_ram #(.DEPTH_LOG(LOG_WIDTH), .DATA_W(RESOL)) u_bank1 (
    .clock   (clock),
    .wr_en   (wr_en_c & wr_bank_q),
    .wr_addr (sample_index),
    .wr_data (sample_value),
    .rd_addr (bank1_rd_addr_c),
    .rd_data (bank1_rd_data)
  );

`ifdef PREV_OVERLAY_EN
  wave_bank_ram #(.DEPTH_LOG(LOG_WIDTH), .DATA_W(RESOL)) u_bank_prev (
    .clock   (clock),
    .wr_en   (copy_wr_q),
    .wr_addr (copy_addr_q),
    .wr_data (prev_wr_data_c),
    .rd_addr (disp_addr_c),
    .rd_data (prev_rd_data)
  );

  assign prev_pixel = prev_pixel_q;
`endif

  assign buf_busy   = pending_q;
  assign overflow   = overflow_q;
  assign swapped    = swapped_q;
  assign wave_pixel = wave_pixel_q;

endmodule

// File: tb/tb_wave_frame_buffer.sv
// Scoreboard bench for wave_frame_buffer: driver pushes timed expectations, negedge monitor checks.
module tb_wave_frame_buffer;

  localparam int K_PIX  = 0;
  localparam int K_SWP  = 1;
  localparam int K_BUSY = 2;
  localparam int K_OVF  = 3;

  typedef struct {
    int    due;
    int    kind;
    logic  exp;
    string name;
  } chk_t;

  logic        clock;
  logic        reset;
  logic        sample_valid;
  logic [9:0]  sample_index;
  logic [9:0]  sample_value;
  logic        wave_ready;
  logic        buf_busy;
  logic        overflow;
  logic        swapped;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        vsync;
  logic        wave_pixel;
`ifdef PREV_OVERLAY_EN
  logic        prev_pixel;
`endif

  chk_t sb[$];
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  wave_frame_buffer dut (
    .clock        (clock),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_index (sample_index),
    .sample_value (sample_value),
    .wave_ready   (wave_ready),
    .buf_busy     (buf_busy),
    .overflow     (overflow),
    .swapped      (swapped),
    .hcount       (hcount),
    .vcount       (vcount),
    .vsync        (vsync),
    .wave_pixel   (wave_pixel)
`ifdef PREV_OVERLAY_EN
    ,
    .prev_pixel   (prev_pixel)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Monitor: compare every expectation whose due cycle is now.
  always @(negedge clock) begin : mon
    logic act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        case (sb[i].kind)
          K_PIX:   act = wave_pixel;
          K_SWP:   act = swapped;
          K_BUSY:  act = buf_busy;
          default: act = overflow;
        endcase
        total_cnt++;
        if (act === sb[i].exp) begin
          pass_cnt++;
        end else begin
          $display("FAIL %s @cyc %0d: got %b expected %b", sb[i].name, cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_at(input int kind, input int delay, input logic exp, input string name);
    chk_t c;
    c.due  = cyc + delay;
    c.kind = kind;
    c.exp  = exp;
    c.name = name;
    sb.push_back(c);
  endtask

  function automatic logic [9:0] val(input int mode, input int idx);
    case (mode)
      0:       return 10'(idx);
      1:       return 10'(1023 - idx);
      2:       return 10'd200;
      default: return 10'd600;
    endcase
  endfunction

  task automatic stream(input int mode, input int count, input bit ready_last);
    for (int i = 0; i < count; i++) begin
      sample_valid = 1'b1;
      sample_index = 10'(i);
      sample_value = val(mode, i);
      wave_ready   = ready_last && (i == count - 1);
      tick();
    end
    sample_valid = 1'b0;
    wave_ready   = 1'b0;
  endtask

  task automatic vsync_pulse(input logic exp_swap, input string tag);
    vsync = 1'b1;
    expect_at(K_SWP, 1, exp_swap, {tag, "_swapped"});
    expect_at(K_SWP, 2, 1'b0, {tag, "_swapped_end"});
    expect_at(K_BUSY, 1, 1'b0, {tag, "_busy_after"});
    tick();
    tick();
    vsync = 1'b0;
    tick();
  endtask

  task automatic probe(input int h, input int v, input logic exp);
    hcount = 11'(h);
    vcount = 10'(v);
    expect_at(K_PIX, 2, exp, $sformatf("pix_h%0d_v%0d", h, v));
    tick();
  endtask

  initial begin
    reset = 1'b1;
    sample_valid = 1'b0;
    sample_index = '0;
    sample_value = '0;
    wave_ready = 1'b0;
    hcount = 11'd100;
    vcount = 10'd590;
    vsync = 1'b0;

    // Reset state
    expect_at(K_BUSY, 1, 1'b0, "rst_busy");
    expect_at(K_OVF,  1, 1'b0, "rst_ovf");
    expect_at(K_SWP,  1, 1'b0, "rst_swp");
    expect_at(K_PIX,  1, 1'b0, "rst_pix");
    tick();
    tick();
    reset = 1'b0;
    tick();

    total_cnt++;
    if (buf_busy !== 1'b0) $display("FAIL direct_rst_busy: got %b", buf_busy);
    else pass_cnt++;
    total_cnt++;
    if (overflow !== 1'b0) $display("FAIL direct_rst_ovf: got %b", overflow);
    else pass_cnt++;
    total_cnt++;
    if (swapped !== 1'b0) $display("FAIL direct_rst_swp: got %b", swapped);
    else pass_cnt++;

    // No frame yet: blank everywhere
    probe(100, 590, 1'b0);
    probe(0, 640, 1'b0);
    probe(1023, 129, 1'b0);

    // Profile value=idx, swap on vsync
    stream(0, 1024, 1'b1);
    expect_at(K_BUSY, 0, 1'b1, "t1_busy_pending");
    total_cnt++;
    if (buf_busy !== 1'b1) $display("FAIL direct_t1_busy: got %b", buf_busy);
    else pass_cnt++;
    tick();
    vsync_pulse(1'b1, "t1");
    probe(100, 588, 1'b0);
    probe(100, 589, 1'b1);
    probe(100, 590, 1'b1);
    probe(100, 591, 1'b1);
    probe(100, 592, 1'b0);
    probe(0, 640, 1'b1);
    probe(1023, 129, 1'b1);
    probe(1023, 127, 1'b0);
    // Out-of-range columns stay blank even where the aliased curve row matches
    probe(1024, 640, 1'b0);
    probe(1100, 602, 1'b0);
    probe(1343, 481, 1'b0);

    // Profile value=1023-idx, then an overflowing sample before vsync
    stream(1, 1024, 1'b1);
    expect_at(K_OVF, 0, 1'b0, "t3_ovf_before");
    sample_valid = 1'b1;
    sample_index = 10'd100;
    sample_value = 10'd0;
    expect_at(K_OVF, 1, 1'b1, "t3_ovf_set");
    expect_at(K_BUSY, 1, 1'b1, "t3_busy");
    tick();
    sample_valid = 1'b0;
    total_cnt++;
    if (overflow !== 1'b1) $display("FAIL direct_t3_ovf: got %b", overflow);
    else pass_cnt++;
    total_cnt++;
    if (buf_busy !== 1'b1) $display("FAIL direct_t3_busy: got %b", buf_busy);
    else pass_cnt++;
    probe(100, 590, 1'b1);
    vsync_pulse(1'b1, "t3");
    probe(100, 178, 1'b1);
    probe(100, 179, 1'b1);
    probe(100, 180, 1'b1);
    probe(100, 181, 1'b0);
    probe(100, 640, 1'b0);
    probe(100, 590, 1'b0);
    probe(0, 129, 1'b1);

    // wave_ready coincident with vsync rise
    stream(2, 1023, 1'b0);
    sample_valid = 1'b1;
    sample_index = 10'd1023;
    sample_value = 10'd200;
    wave_ready = 1'b1;
    vsync = 1'b1;
    expect_at(K_SWP,  1, 1'b1, "t4_swapped");
    expect_at(K_BUSY, 1, 1'b0, "t4_busy");
    expect_at(K_BUSY, 2, 1'b0, "t4_busy_hold");
    expect_at(K_OVF,  1, 1'b1, "t4_ovf_sticky");
    tick();
    sample_valid = 1'b0;
    wave_ready = 1'b0;
    expect_at(K_SWP, 1, 1'b0, "t4_swapped_end");
    tick();
    vsync = 1'b0;
    tick();
    probe(1023, 540, 1'b1);
    probe(5, 541, 1'b1);
    probe(5, 542, 1'b0);
    probe(5, 540, 1'b1);

    // Mid-profile reset, still probing a lit pixel (5,540)
    stream(0, 500, 1'b0);
    reset = 1'b1;
    sample_valid = 1'b1;
    sample_index = 10'd500;
    sample_value = 10'd500;
    expect_at(K_BUSY, 1, 1'b0, "t6_rst_busy");
    expect_at(K_OVF,  1, 1'b0, "t6_rst_ovf");
    expect_at(K_SWP,  1, 1'b0, "t6_rst_swp");
    expect_at(K_PIX,  1, 1'b0, "t6_rst_pix");
    tick();
    total_cnt++;
    if (overflow !== 1'b0) $display("FAIL direct_t6_ovf_cleared: got %b", overflow);
    else pass_cnt++;
    reset = 1'b0;
    sample_valid = 1'b0;
    expect_at(K_PIX, 2, 1'b0, "t6_blank_after_rst");
    tick();
    probe(5, 540, 1'b0);
    vsync_pulse(1'b0, "t6_nopend");
    probe(5, 540, 1'b0);
    stream(3, 1024, 1'b1);
    vsync_pulse(1'b1, "t6");
    probe(10, 338, 1'b0);
    probe(10, 339, 1'b1);
    probe(10, 340, 1'b1);
    probe(10, 540, 1'b0);

    repeat (4) tick();
    while (sb.size() > 0) begin
      total_cnt++;
      $display("FAIL %s: expectation due at cyc %0d never checked (now %0d)", sb[0].name, sb[0].due, cyc);
      void'(sb.pop_front());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
